// File: rtl/stopwatch_mode_ctrl.sv
// Stopwatch mode controller.
// Conditions three raw front-panel inputs (synchronise, then debounce), turns
// the pause button into single press events, runs the RUN / PAUSED / ADJ_SEC /
// ADJ_MIN mode FSM, and produces the counter increment strobe and the display
// blink enable from a free-running 1 Hz / 2 Hz divider.

// ---------------------------------------------------------------------------
// One input channel: 2-flop synchroniser followed by a stability debouncer.
// The debounced level only follows the synchronised level after it has
// disagreed for DB_CYCLES consecutive edges; any agreeing edge restarts the wait.
// ---------------------------------------------------------------------------
module stopwatch_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int              DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync_meta;
  logic            sync_q;
  logic [DB_W-1:0] stable_cnt;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values
      // on the same edge, so this really is a two-stage shift and not a wire.
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Accept the new level only after it has been stable for DB_CYCLES edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync_q == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DB_LAST) begin
      stable_cnt <= '0;
      level      <= sync_q;
    end else begin
      stable_cnt <= stable_cnt + DB_W'(1);
    end
  end

endmodule

// ---------------------------------------------------------------------------
// Top level.
// ---------------------------------------------------------------------------
module stopwatch_mode_ctrl #(
  parameter int ONE_HZ_DIV = 100000000,
  parameter int DB_CYCLES  = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic regular_mode,
  output logic pause_mode,
  output logic adjust_seconds_mode,
  output logic adjust_minutes_mode,
  output logic inc_en,
  output logic blink
);

  localparam int               DIV_W    = (ONE_HZ_DIV > 1) ? $clog2(ONE_HZ_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ONE_HZ_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(ONE_HZ_DIV / 2 - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAUSED,
    ST_ADJ_SEC,
    ST_ADJ_MIN
  } state_t;

  // Conditioned input levels.
  logic db_pause;
  logic db_adj;
  logic db_sel;

  // Event stage feeding the FSM.
  logic pause_prev;
  logic press_q;
  logic adj_q;
  logic sel_q;

  // Tick divider.
  logic [DIV_W-1:0] div_cnt;
  logic             tick_1hz;
  logic             tick_2hz;

  // Mode FSM.
  state_t state_q;
  state_t resume_q;
  state_t state_nxt;
  logic   in_adj;
  logic   nxt_adj;

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_pause),
    .level (db_pause)
  );

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adj (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw_adj),
    .level (db_adj)
  );

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw_sel),
    .level (db_sel)
  );

  // Register the switch levels and turn the button's rising edge into a
  // single-cycle press; all three reach the FSM on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_prev <= 1'b0;
      press_q    <= 1'b0;
      adj_q      <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      pause_prev <= db_pause;
      press_q    <= db_pause & ~pause_prev;
      adj_q      <= db_adj;
      sel_q      <= db_sel;
    end
  end

  // Free-running divider; mode changes never disturb its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick_1hz = (div_cnt == DIV_LAST);
  assign tick_2hz = (div_cnt == DIV_HALF) | tick_1hz;

  assign in_adj  = (state_q == ST_ADJ_SEC) || (state_q == ST_ADJ_MIN);
  assign nxt_adj = (state_nxt == ST_ADJ_SEC) || (state_nxt == ST_ADJ_MIN);

  // Next-state selection: adjust switch first, then leaving adjust, then pause.
  always_comb begin
    // NOTE: the default assignment up front guarantees state_nxt is written on
    // every path, so no latch can be inferred.
    state_nxt = state_q;
    if (adj_q) begin
      state_nxt = sel_q ? ST_ADJ_SEC : ST_ADJ_MIN;
    end else if (in_adj) begin
      state_nxt = resume_q;
    end else if (press_q) begin
      state_nxt = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  // State, resume memory and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= ST_RUN;
      resume_q            <= ST_RUN;
      regular_mode        <= 1'b1;
      pause_mode          <= 1'b0;
      adjust_seconds_mode <= 1'b0;
      adjust_minutes_mode <= 1'b0;
      inc_en              <= 1'b0;
      blink               <= 1'b0;
    end else begin
      state_q <= state_nxt;

      // Only a RUN/PAUSED -> ADJ entry records where to come back to;
      // hopping between the two adjust states keeps the saved mode.
      if (nxt_adj && !in_adj) begin
        resume_q <= state_q;
      end

      // Mode flags track the state register exactly, one-hot.
      regular_mode        <= (state_nxt == ST_RUN);
      pause_mode          <= (state_nxt == ST_PAUSED);
      adjust_seconds_mode <= (state_nxt == ST_ADJ_SEC);
      adjust_minutes_mode <= (state_nxt == ST_ADJ_MIN);

      // Qualified by the state before this edge; the self-mask keeps the
      // strobe single-cycle even for tiny divider settings.
      inc_en <= ~inc_en &
                (((state_q == ST_RUN) & tick_1hz) | (in_adj & tick_2hz));

      // Blink starts lit on entry, toggles at 2 Hz while adjusting.
      if (!nxt_adj) begin
        blink <= 1'b0;
      end else if (!in_adj) begin
        blink <= 1'b1;
      end else if (tick_2hz) begin
        blink <= ~blink;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Directed bench for stopwatch_mode_ctrl with ONE_HZ_DIV=8, DB_CYCLES=4.
// Timing model: after the edge-th rising edge since reset release the divider
// holds edge%8, so a 1 Hz strobe follows edges divisible by 8 and a 2 Hz
// strobe (and blink toggle) follows edges divisible by 4. A raw level first
// sampled on edge s shows on the mode outputs after edge s+7.
module tb_stopwatch_mode_ctrl;

  localparam logic [3:0] M_RUN = 4'b1000;
  localparam logic [3:0] M_PAU = 4'b0100;
  localparam logic [3:0] M_SEC = 4'b0010;
  localparam logic [3:0] M_MIN = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_pause = 1'b0;
  logic sw_adj = 1'b0;
  logic sw_sel = 1'b0;
  logic regular_mode, pause_mode, adjust_seconds_mode, adjust_minutes_mode;
  logic inc_en, blink;
  logic [3:0] modes;

  int checks = 0;
  int errors = 0;
  int ec;
  logic bl;

  stopwatch_mode_ctrl #(.ONE_HZ_DIV(8), .DB_CYCLES(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .btn_pause           (btn_pause),
    .sw_adj              (sw_adj),
    .sw_sel              (sw_sel),
    .regular_mode        (regular_mode),
    .pause_mode          (pause_mode),
    .adjust_seconds_mode (adjust_seconds_mode),
    .adjust_minutes_mode (adjust_minutes_mode),
    .inc_en              (inc_en),
    .blink               (blink)
  );

  assign modes = {regular_mode, pause_mode, adjust_seconds_mode, adjust_minutes_mode};

  always #5 clk = ~clk;

  // Edges since the latest reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) ec <= 0;
    else      ec <= ec + 1;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run n edges inside an adjust state, checking blink, inc_en and mode.
  task automatic adj_run(input int n, input logic [3:0] m);
    for (int i = 0; i < n; i++) begin
      step(1);
      if (ec % 4 == 0) bl = ~bl;
      check("adj_mode", modes, m);
      check("adj_blink", blink, bl);
      check("adj_inc", inc_en, ec % 4 == 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_modes", modes, M_RUN);
    check("rst_inc", inc_en, 1'b0);
    check("rst_blink", blink, 1'b0);
    #3 rst = 1'b1;

    // ---- RUN: inc_en after edges 8 and 16 (seen by the counter on 9, 17) ----
    for (int i = 0; i < 17; i++) begin
      step(1);
      check("run_mode", modes, M_RUN);
      check("run_inc", inc_en, ec % 8 == 0);
    end

    // ---- press 10 cycles: PAUSED 7 edges after first sampling edge ----
    btn_pause = 1'b1;
    step(7);
    check("p1_before", modes, M_RUN);
    step(1);
    check("p1_after", modes, M_PAU);
    step(2);
    btn_pause = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      check("paused_mode", modes, M_PAU);
      check("paused_inc", inc_en, 1'b0);
    end

    // ---- press and hold 50 cycles: exactly one toggle back to RUN ----
    btn_pause = 1'b1;
    step(7);
    check("p2_before", modes, M_PAU);
    step(1);
    check("p2_after", modes, M_RUN);
    for (int i = 0; i < 42; i++) begin
      step(1);
      check("hold_mode", modes, M_RUN);
      check("hold_inc", inc_en, ec % 8 == 0);
    end
    btn_pause = 1'b0;
    step(10);
    check("hold_release", modes, M_RUN);

    // ---- bounce 1-0-1-0 then stable 1 ----
    btn_pause = 1'b1; step(1);
    btn_pause = 1'b0; step(1);
    btn_pause = 1'b1; step(1);
    btn_pause = 1'b0; step(1);
    btn_pause = 1'b1;
    step(7);
    check("bounce_before", modes, M_RUN);
    step(1);
    check("bounce_after", modes, M_PAU);
    step(10);
    check("bounce_single", modes, M_PAU);
    btn_pause = 1'b0;
    step(10);

    // ---- adjust seconds from PAUSED ----
    sw_adj = 1'b1;
    sw_sel = 1'b1;
    step(7);
    check("as_before", modes, M_PAU);
    check("as_before_inc", inc_en, 1'b0);
    step(1);
    check("as_entry", modes, M_SEC);
    check("as_entry_blink", blink, 1'b1);
    check("as_entry_inc", inc_en, 1'b0);
    bl = 1'b1;
    adj_run(12, M_SEC);

    // ---- switch to minutes: blink phase continues ----
    sw_sel = 1'b0;
    adj_run(7, M_SEC);
    adj_run(1, M_MIN);
    adj_run(8, M_MIN);

    // ---- leave adjust: back to the saved PAUSED ----
    sw_adj = 1'b0;
    adj_run(7, M_MIN);
    step(1);
    check("ax_mode", modes, M_PAU);
    check("ax_blink", blink, 1'b0);
    check("ax_inc", inc_en, ec % 4 == 0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("ax_paused_inc", inc_en, 1'b0);
      check("ax_paused_blink", blink, 1'b0);
    end

    // ---- back to RUN, then adjust with a discarded pause press ----
    btn_pause = 1'b1;
    step(8);
    check("p3_after", modes, M_RUN);
    step(2);
    btn_pause = 1'b0;
    step(10);
    sw_adj = 1'b1;
    step(7);
    check("am_before", modes, M_RUN);
    step(1);
    check("am_entry", modes, M_MIN);
    check("am_entry_blink", blink, 1'b1);
    check("am_entry_inc", inc_en, ec % 8 == 0);
    bl = 1'b1;
    btn_pause = 1'b1;
    adj_run(16, M_MIN);
    btn_pause = 1'b0;
    adj_run(10, M_MIN);
    sw_adj = 1'b0;
    adj_run(7, M_MIN);
    step(1);
    check("am_exit", modes, M_RUN);
    check("am_exit_blink", blink, 1'b0);

    // ---- reset in the middle of adjust, with a select change pending ----
    sw_adj = 1'b1;
    step(8);
    check("ra_entry", modes, M_MIN);
    sw_sel = 1'b1;
    step(3);
    #2 rst = 1'b0;
    #1;
    check("ra_async_mode", modes, M_RUN);
    check("ra_async_blink", blink, 1'b0);
    check("ra_async_inc", inc_en, 1'b0);
    sw_sel = 1'b0;
    repeat (2) @(posedge clk);
    check("ra_held_mode", modes, M_RUN);
    #4 rst = 1'b1;

    // sw_adj is still raised, so it must be re-sampled from scratch.
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("rr_mode", modes, M_RUN);
      check("rr_inc", inc_en, 1'b0);
    end
    step(1);
    check("rr_entry", modes, M_MIN);
    check("rr_entry_inc", inc_en, 1'b1);
    check("rr_entry_blink", blink, 1'b1);
    sw_adj = 1'b0;
    step(7);
    check("rr_before_exit", modes, M_MIN);
    step(1);
    check("rr_exit", modes, M_RUN);
    check("rr_exit_blink", blink, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_mode_ctrl.md
STOPWATCH_MODE_CTRL -- requirements
Module: stopwatch_mode_ctrl

Interface
REQ-001 Parameters SHALL be as follows.
- ONE_HZ_DIV, default 100000000: clk cycles per 1 Hz tick.
- DB_CYCLES, default 1000000: consecutive stable cycles required to accept a new debounced level.
REQ-002 Ports SHALL be as follows.
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_pause  input  1  raw pause push-button; asynchronous, bouncing.
- sw_adj  input  1  raw adjust switch; asynchronous, bouncing.
- sw_sel  input  1  raw select switch (1 = seconds, 0 = minutes); asynchronous, bouncing.
- regular_mode  output  1  counting mode.
- pause_mode  output  1  paused mode.
- adjust_seconds_mode  output  1  adjust-seconds mode.
- adjust_minutes_mode  output  1  adjust-minutes mode.
- inc_en  output  1  one-cycle increment strobe to the stopwatch counter.
- blink  output  1  display blink enable for the adjusted field.

Function
REQ-003 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-004 Debouncing SHALL work as follows.
- Each synchronized input SHALL have its own debounced register and stability counter.
- The debounced value SHALL take the synchronized value on the edge where the synchronized value has differed from it for DB_CYCLES consecutive edges.
- Any mismatch gap SHALL clear the stability counter.
REQ-005 A pause press SHALL be a one-cycle pulse on the 0->1 transition of debounced btn_pause; holding the button SHALL NOT repeat the pulse.
REQ-006 The FSM SHALL have states RUN, PAUSED, ADJ_SEC and ADJ_MIN.
REQ-007 Mode outputs SHALL be a one-hot decode of the state register: RUN->regular_mode, PAUSED->pause_mode, ADJ_SEC->adjust_seconds_mode, ADJ_MIN->adjust_minutes_mode. Exactly one SHALL be high at all times after reset.
REQ-008 FSM transitions SHALL be as follows, in priority order.
- Debounced sw_adj=1: next state is ADJ_SEC if debounced sw_sel=1, else ADJ_MIN.
- Debounced sw_adj=0 while in an ADJ state: return to the saved resume state.
- Pause press in RUN -> PAUSED; pause press in PAUSED -> RUN.
REQ-009 Resume state handling SHALL be as follows.
- On entry to an ADJ state from RUN or PAUSED, that state SHALL be saved as the resume state.
- ADJ_SEC<->ADJ_MIN switching via sw_sel SHALL NOT alter the saved resume state.
REQ-010 A pause press occurring while in an ADJ state or while sw_adj=1 SHALL be discarded.
REQ-011 Tick generation SHALL work as follows.
- A free-running divider SHALL count 0..ONE_HZ_DIV-1 and wrap to 0.
- tick_1hz SHALL assert when the divider equals ONE_HZ_DIV-1.
- tick_2hz SHALL assert at ONE_HZ_DIV/2-1 (integer division) and at ONE_HZ_DIV-1.
- The divider SHALL NOT be reset by mode changes.
REQ-012 inc_en SHALL be a registered pulse, one cycle after the qualifying tick.
- It SHALL pulse on tick_1hz while in RUN.
- It SHALL pulse on tick_2hz while in ADJ_SEC or ADJ_MIN.
- It SHALL never pulse in PAUSED.
- It SHALL never be high for two consecutive cycles.
REQ-013 blink SHALL be as follows.
- In ADJ states, it SHALL toggle on every tick_2hz.
- In RUN or PAUSED, it SHALL be 0.
- On entry to an ADJ state, it SHALL start at 1 on the next cycle.
REQ-014 Latency: for a raw input held stable, the mode outputs SHALL change exactly DB_CYCLES+3 rising edges after the first edge that samples the new raw level.
REQ-015 If a mode change and a qualifying tick fall on the same edge, inc_en SHALL be qualified by the state before that edge.

Reset
REQ-016 When rst=0, the block SHALL immediately and asynchronously force the following.
- State RUN, resume state RUN.
- regular_mode=1 and all other mode outputs 0.
- inc_en=0, blink=0.
- Divider, stability counters, synchronizers and debounced registers all 0.
REQ-017 The block SHALL leave reset on the first rising clk edge after rst returns to 1. Reset asserted mid-debounce or mid-adjust SHALL discard all pending state.

Verification (ONE_HZ_DIV=8, DB_CYCLES=4)
REQ-018 The bench SHALL cover these directed scenarios.
- Release rst with all inputs 0 -> regular_mode=1; inc_en pulses once per 8 cycles, the first pulse on the 9th edge after reset release.
- Press btn_pause for 10 cycles -> pause_mode=1 exactly 7 edges after the first sampling edge; no inc_en while paused.
- Press again -> regular_mode returns; holding the button for 50 cycles yields a single toggle.
- btn_pause bouncing 1-0-1-0 with a 2-cycle period, then stable 1 -> a single PAUSED transition, timed from the start of the stable period.
- From PAUSED: sw_adj=1, sw_sel=1 -> adjust_seconds_mode=1, blink toggles every 4 cycles, inc_en every 4 cycles; sw_sel=0 -> adjust_minutes_mode=1; sw_adj=0 -> pause_mode=1 (resume state preserved).
- Pause press while sw_adj=1 -> ignored; sw_adj=0 -> return to the saved state. Assert rst mid-adjust -> RUN, blink=0 immediately, without waiting for a clock edge.
